cv32e40p_rf_writeback: RTL and testbench
========================================

# cv32e40p_rf_writeback

Write-back arbiter and pending-register scoreboard that drives both write ports of the core register file. It merges three result producers onto those ports: the EX stage, the LSU response and the APU/multicycle result. The APU stream is buffered in a small FIFO whenever port B is taken. A per-register busy vector is kept for the ID-stage hazard logic.

## Interface
Parameters:
- ADDR_WIDTH, 5, register address width (6 when FP registers are present).
- DATA_WIDTH, 32, write data width.
- APU_FIFO_DEPTH, 2, APU result buffer entries (≥1, power of two).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- ex_we_i  in  1  EX result write request (always accepted).
- ex_waddr_i  in  ADDR_WIDTH  EX destination.
- ex_wdata_i  in  DATA_WIDTH  EX data.
- lsu_valid_i  in  1  load response write request (always accepted).
- lsu_waddr_i  in  ADDR_WIDTH  load destination.
- lsu_wdata_i  in  DATA_WIDTH  load data.
- apu_valid_i  in  1  APU result valid.
- apu_ready_o  out  1  APU result accepted.
- apu_waddr_i  in  ADDR_WIDTH  APU destination.
- apu_wdata_i  in  DATA_WIDTH  APU data.
- sb_set_i  in  1  mark a destination pending (LSU/APU issue).
- sb_addr_i  in  ADDR_WIDTH  register to mark.
- busy_o  out  2**ADDR_WIDTH  pending-register vector.
- we_a_o, waddr_a_o, wdata_a_o  out  1/ADDR_WIDTH/DATA_WIDTH  RF port A.
- we_b_o, waddr_b_o, wdata_b_o  out  1/ADDR_WIDTH/DATA_WIDTH  RF port B.
- waw_conflict_o  out  1  same-cycle A/B same-address pulse.

## Operation
- Port A carries EX only. we_a_o = ex_we_i && ex_waddr_i != 0.
- Port B priority, highest first:
  - LSU.
  - FIFO head.
  - APU bypass (only when the FIFO is empty).
- Writes to address 0 never assert a write enable. They still complete their handshake and pop or accept as normal.
- APU accept:
  - apu_ready_o = FIFO count < APU_FIFO_DEPTH. This uses the registered count only; a pop in the same cycle does not free space.
  - An accepted APU result bypasses when the FIFO is empty and lsu_valid_i is low. Otherwise it is pushed.
  - APU results reach the RF in acceptance order.
- FIFO pop: occurs in any cycle where lsu_valid_i is low and count > 0. Push and pop in the same cycle leaves count unchanged.
- WAW conflict: when we_a_o and we_b_o would both be asserted with equal addresses:
  - port A is suppressed (we_a_o = 0);
  - port B writes;
  - waw_conflict_o = 1 for that cycle.
- Scoreboard:
  - busy[sb_addr_i] is set on sb_set_i.
  - busy[waddr_b_o] is cleared on any port-B write.
  - Set and clear of the same address in one cycle: set wins.
  - busy_o[0] is constant 0.
  - sb_set_i to address 0 is ignored.

## Timing
- Reset values:
  - busy_o = 0, FIFO empty, apu_ready_o = 1.
  - All write enables are 0 while rst_n is low (combinational, with empty-FIFO state).
  - waw_conflict_o = 0.
- EX and LSU paths are purely combinational, 0-cycle. The RF samples them at the next rising edge.
- APU latency is 0 cycles when bypassed. Otherwise it is 1 + (cycles port B is held by the LSU) + (entries ahead in the FIFO).
- busy_o is registered. Updates appear the cycle after the set or clear event.
- Reset asserted mid-operation discards FIFO contents and clears busy without any RF write.

## Configuration
- Macro: CV32E40P_RF_WB_APU_BYPASS_EN.
- Defined: the empty-FIFO APU bypass is present, as described above.
- Undefined: every accepted APU result is pushed. Minimum APU latency is 1 cycle, and port B can only be driven from LSU or the FIFO head. This removes the APU-to-RF combinational path.

## Structure
- In cv32e40p_pkg: typedef struct rf_wb_req_t {waddr, wdata}.
- Sub-module cv32e40p_rf_wb_fifo:
  - synchronous-push/pop circular buffer of rf_wb_req_t;
  - wrap-around read/write pointers;
  - outputs count, empty, full.
- Arbitration and scoreboard logic live in the top module.

## Test plan
- Reset:
  - stimulus: hold rst_n low with all inputs active;
  - response: we_a_o = we_b_o = 0, busy_o = 0, apu_ready_o = 1.
- Bypass:
  - stimulus: FIFO empty, lsu_valid_i = 0, APU writes x5 = 0xDEADBEEF;
  - response: same cycle we_b_o = 1, waddr_b_o = 5, wdata_b_o = 0xDEADBEEF;
  - with the macro undefined the write appears one cycle later instead.
- LSU contention:
  - stimulus: LSU writes x3 for 4 cycles while the APU offers x7, x8, x9 (depth 2);
  - response: x7 and x8 are buffered and apu_ready_o falls;
  - after the LSU burst, x7 then x8 are written in order, then x9 is accepted.
- WAW conflict:
  - stimulus: EX writes x10 = 1 and LSU writes x10 = 2 in the same cycle;
  - response: we_a_o = 0, port B writes 2, waw_conflict_o = 1.
- Scoreboard:
  - stimulus: sb_set_i for x12, then LSU writes x12 in the same cycle as a new sb_set_i for x12;
  - response: busy_o[12] stays 1. A later LSU write to x12 clears it one cycle later.
- x0 writes:
  - stimulus: EX, LSU and APU each target address 0;
  - response: no write enable is asserted, the APU handshake completes, busy_o[0] stays 0.

Source files
------------

// File: rtl/cv32e40p_rf_writeback_pkg.sv
// Shared write-back types: a register-file write request as buffered by the APU FIFO.
// Field widths cover the largest supported configuration (FP registers, 32-bit data).
package cv32e40p_pkg;

  localparam int RF_WB_ADDR_MAX = 6;
  localparam int RF_WB_DATA_MAX = 32;

  typedef struct packed {
    logic [RF_WB_ADDR_MAX-1:0] waddr;
    logic [RF_WB_DATA_MAX-1:0] wdata;
  } rf_wb_req_t;

endpackage

// File: rtl/cv32e40p_rf_writeback_if.sv
// Result producers, register-file write ports and scoreboard signals of the write-back block.
// The slave modport is the write-back block; the master modport is the pipeline side.
interface cv32e40p_rf_writeback_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);

  logic                     ex_we_i;
  logic [ADDR_WIDTH-1:0]    ex_waddr_i;
  logic [DATA_WIDTH-1:0]    ex_wdata_i;
  logic                     lsu_valid_i;
  logic [ADDR_WIDTH-1:0]    lsu_waddr_i;
  logic [DATA_WIDTH-1:0]    lsu_wdata_i;
  logic                     apu_valid_i;
  logic                     apu_ready_o;
  logic [ADDR_WIDTH-1:0]    apu_waddr_i;
  logic [DATA_WIDTH-1:0]    apu_wdata_i;
  logic                     sb_set_i;
  logic [ADDR_WIDTH-1:0]    sb_addr_i;
  logic [2**ADDR_WIDTH-1:0] busy_o;
  logic                     we_a_o;
  logic [ADDR_WIDTH-1:0]    waddr_a_o;
  logic [DATA_WIDTH-1:0]    wdata_a_o;
  logic                     we_b_o;
  logic [ADDR_WIDTH-1:0]    waddr_b_o;
  logic [DATA_WIDTH-1:0]    wdata_b_o;
  logic                     waw_conflict_o;

  modport slave (
    input  ex_we_i, ex_waddr_i, ex_wdata_i,
    input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    input  apu_valid_i, apu_waddr_i, apu_wdata_i,
    input  sb_set_i, sb_addr_i,
    output apu_ready_o, busy_o,
    output we_a_o, waddr_a_o, wdata_a_o,
    output we_b_o, waddr_b_o, wdata_b_o,
    output waw_conflict_o
  );

  modport master (
    output ex_we_i, ex_waddr_i, ex_wdata_i,
    output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    output apu_valid_i, apu_waddr_i, apu_wdata_i,
    output sb_set_i, sb_addr_i,
    input  apu_ready_o, busy_o,
    input  we_a_o, waddr_a_o, wdata_a_o,
    input  we_b_o, waddr_b_o, wdata_b_o,
    input  waw_conflict_o
  );

endinterface

// File: rtl/cv32e40p_rf_wb_fifo.sv
// Circular buffer of pending APU write requests with wrap-around pointers.
// Pushes while full and pops while empty are ignored.
module cv32e40p_rf_wb_fifo
  import cv32e40p_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  rf_wb_req_t                   data_i,
  input  logic                         pop_i,
  output rf_wb_req_t                   data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic                         full_o
);

  localparam int                 PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                 CNT_W    = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0]   LAST_PTR = PTR_W'(DEPTH-1);
  localparam logic [CNT_W-1:0]   DEPTH_C  = CNT_W'(DEPTH);

  rf_wb_req_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push_i && !full_o;
    pop_ok   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; the pointers alone decide validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/cv32e40p_rf_writeback.sv
// Register-file write-back arbiter (EX on port A; LSU > APU FIFO > APU bypass on port B)
// plus pending-register scoreboard. Define CV32E40P_RF_WB_APU_BYPASS_EN for the empty-FIFO APU bypass.
module cv32e40p_rf_writeback
  import cv32e40p_pkg::*;
#(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int APU_FIFO_DEPTH = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  cv32e40p_rf_writeback_if.slave wb
);

  localparam int NREG = 2**ADDR_WIDTH;

  logic [NREG-1:0]                     busy_q, busy_d;
  rf_wb_req_t                          fifo_in, fifo_head;
  logic [$clog2(APU_FIFO_DEPTH+1)-1:0] fifo_count;
  logic                                fifo_empty, fifo_full;
  logic                                fifo_push, fifo_pop;
  logic                                apu_ready, apu_acc, apu_byp;
  logic                                b_req, we_b, we_a_raw, waw;
  logic [ADDR_WIDTH-1:0]               b_addr;
  logic [DATA_WIDTH-1:0]               b_data;
  logic                                unused_fifo;

  assign unused_fifo = ^{fifo_count, fifo_head};

  assign fifo_in.waddr = RF_WB_ADDR_MAX'(wb.apu_waddr_i);
  assign fifo_in.wdata = RF_WB_DATA_MAX'(wb.apu_wdata_i);

  cv32e40p_rf_wb_fifo #(
    .DEPTH (APU_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .data_i  (fifo_in),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    // Space is judged on the registered count only, so a same-cycle pop never frees a slot.
    apu_ready = !fifo_full;
    apu_acc   = wb.apu_valid_i && apu_ready;
`ifdef CV32E40P_RF_WB_APU_BYPASS_EN
    apu_byp   = apu_acc && fifo_empty && !wb.lsu_valid_i;
`else
    apu_byp   = 1'b0;
`endif
    fifo_push = apu_acc && !apu_byp;
    fifo_pop  = !wb.lsu_valid_i && !fifo_empty;

    b_req  = 1'b0;
    b_addr = '0;
    b_data = '0;
    if (wb.lsu_valid_i) begin
      b_req  = 1'b1;
      b_addr = wb.lsu_waddr_i;
      b_data = wb.lsu_wdata_i;
    end else if (!fifo_empty) begin
      b_req  = 1'b1;
      b_addr = fifo_head.waddr[ADDR_WIDTH-1:0];
      b_data = fifo_head.wdata[DATA_WIDTH-1:0];
    end else if (apu_byp) begin
      b_req  = 1'b1;
      b_addr = wb.apu_waddr_i;
      b_data = wb.apu_wdata_i;
    end

    // x0 requests still travel the arbiter but never raise an enable.
    we_b     = rst_n && b_req && (b_addr != '0);
    we_a_raw = rst_n && wb.ex_we_i && (wb.ex_waddr_i != '0);
    waw      = we_a_raw && we_b && (wb.ex_waddr_i == b_addr);

    // Set after clear so a same-cycle set on the retiring register wins.
    busy_d = busy_q;
    if (we_b) busy_d[b_addr] = 1'b0;
    if (wb.sb_set_i && (wb.sb_addr_i != '0)) busy_d[wb.sb_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign wb.apu_ready_o    = apu_ready;
  assign wb.busy_o         = busy_q;
  assign wb.we_a_o         = we_a_raw && !waw;
  assign wb.waddr_a_o      = wb.ex_waddr_i;
  assign wb.wdata_a_o      = wb.ex_wdata_i;
  assign wb.we_b_o         = we_b;
  assign wb.waddr_b_o      = b_addr;
  assign wb.wdata_b_o      = b_data;
  assign wb.waw_conflict_o = waw;

endmodule

// File: tb/tb_cv32e40p_rf_writeback.sv
// Scoreboard bench for cv32e40p_rf_writeback: directed stimulus queues expected RF writes,
// a negedge monitor retires them as ports A/B write.
module tb_cv32e40p_rf_writeback;

  logic clk;
  logic rst_n;

  cv32e40p_rf_writeback_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) wb ();

  cv32e40p_rf_writeback #(
    .ADDR_WIDTH     (5),
    .DATA_WIDTH     (32),
    .APU_FIFO_DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wb)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic        w;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_lsu[$];
  exp_t exp_apu[$];
  int   checks = 0;
  int   passes = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb.ex_we_i     = 1'b0; wb.ex_waddr_i  = '0; wb.ex_wdata_i  = '0;
    wb.lsu_valid_i = 1'b0; wb.lsu_waddr_i = '0; wb.lsu_wdata_i = '0;
    wb.apu_valid_i = 1'b0; wb.apu_waddr_i = '0; wb.apu_wdata_i = '0;
    wb.sb_set_i    = 1'b0; wb.sb_addr_i   = '0;
  endtask

  task automatic lsu(input logic [4:0] a, input logic [31:0] d);
    wb.lsu_valid_i = 1'b1; wb.lsu_waddr_i = a; wb.lsu_wdata_i = d;
  endtask

  task automatic apu(input logic [4:0] a, input logic [31:0] d);
    wb.apu_valid_i = 1'b1; wb.apu_waddr_i = a; wb.apu_wdata_i = d;
  endtask

  // Monitor: every RF write must match the oldest expected write of its source.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (wb.we_b_o === 1'b1) begin
      if (wb.lsu_valid_i === 1'b1) begin
        if (exp_lsu.size() == 0) begin
          checks++;
          $display("FAIL portb_lsu_unexpected: got write x%0d=0x%0h required none", wb.waddr_b_o, wb.wdata_b_o);
        end else begin
          e = exp_lsu.pop_front();
          chk("portb_lsu", {wb.waddr_b_o, wb.wdata_b_o, wb.waw_conflict_o}, {e.a, e.d, e.w});
        end
      end else begin
        if (exp_apu.size() == 0) begin
          checks++;
          $display("FAIL portb_apu_unexpected: got write x%0d=0x%0h required none", wb.waddr_b_o, wb.wdata_b_o);
        end else begin
          e = exp_apu.pop_front();
          chk("portb_apu", {wb.waddr_b_o, wb.wdata_b_o, wb.waw_conflict_o}, {e.a, e.d, e.w});
        end
      end
    end else if (wb.waw_conflict_o !== 1'b0) begin
      checks++;
      $display("FAIL waw_without_write: got waw=%b required 0", wb.waw_conflict_o);
    end
    if (wb.we_a_o === 1'b1) begin
      if (exp_a.size() == 0) begin
        checks++;
        $display("FAIL porta_unexpected: got write x%0d=0x%0h required none", wb.waddr_a_o, wb.wdata_a_o);
      end else begin
        e = exp_a.pop_front();
        chk("porta", {wb.waddr_a_o, wb.wdata_a_o}, {e.a, e.d});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    idle();

    // Reset with every requester active
    wb.ex_we_i = 1'b1; wb.ex_waddr_i = 5'd3; wb.ex_wdata_i = 32'h1;
    lsu(5'd4, 32'h2);
    apu(5'd5, 32'h3);
    wb.sb_set_i = 1'b1; wb.sb_addr_i = 5'd6;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we_a", wb.we_a_o, 0);
    chk("rst_we_b", wb.we_b_o, 0);
    chk("rst_busy", wb.busy_o, 0);
    chk("rst_apu_ready", wb.apu_ready_o, 1);
    chk("rst_waw", wb.waw_conflict_o, 0);
    tick();
    idle();
    rst_n = 1'b1;
    tick();

    // APU bypass to x5
    apu(5'd5, 32'hDEADBEEF);
    exp_apu.push_back('{5'd5, 32'hDEADBEEF, 1'b0});
    @(negedge clk);
    chk("byp_apu_ready", wb.apu_ready_o, 1);
`ifdef CV32E40P_RF_WB_APU_BYPASS_EN
    chk("byp_same_cycle_we_b", wb.we_b_o, 1);
`else
    chk("byp_same_cycle_we_b", wb.we_b_o, 0);
`endif
    tick();
    idle();
    @(negedge clk);
`ifdef CV32E40P_RF_WB_APU_BYPASS_EN
    chk("byp_next_cycle_we_b", wb.we_b_o, 0);
`else
    chk("byp_next_cycle_we_b", wb.we_b_o, 1);
`endif
    tick();
    tick();

    // LSU burst to x3 while APU offers x7, x8, x9
    for (int i = 0; i < 4; i++) exp_lsu.push_back('{5'd3, 32'h300 + i, 1'b0});
    exp_apu.push_back('{5'd7, 32'h700, 1'b0});
    exp_apu.push_back('{5'd8, 32'h800, 1'b0});
    exp_apu.push_back('{5'd9, 32'h900, 1'b0});
    lsu(5'd3, 32'h300); apu(5'd7, 32'h700);
    @(negedge clk); chk("cont_ready_c0", wb.apu_ready_o, 1);
    tick(); lsu(5'd3, 32'h301); apu(5'd8, 32'h800);
    @(negedge clk); chk("cont_ready_c1", wb.apu_ready_o, 1);
    tick(); lsu(5'd3, 32'h302); apu(5'd9, 32'h900);
    @(negedge clk); chk("cont_ready_c2", wb.apu_ready_o, 0);
    tick(); lsu(5'd3, 32'h303);
    @(negedge clk); chk("cont_ready_c3", wb.apu_ready_o, 0);
    tick(); wb.lsu_valid_i = 1'b0;
    @(negedge clk); chk("cont_ready_c4", wb.apu_ready_o, 0);
    chk("cont_head_c4", {wb.we_b_o, wb.waddr_b_o}, {1'b1, 5'd7});
    tick();
    @(negedge clk); chk("cont_ready_c5", wb.apu_ready_o, 1);
    tick(); idle();
    tick(); tick();

    // WAW on x10, then plain EX write, then EX and LSU to different registers
    wb.ex_we_i = 1'b1; wb.ex_waddr_i = 5'd10; wb.ex_wdata_i = 32'd1;
    lsu(5'd10, 32'd2);
    exp_lsu.push_back('{5'd10, 32'd2, 1'b1});
    @(negedge clk);
    chk("waw_we_a", wb.we_a_o, 0);
    chk("waw_flag", wb.waw_conflict_o, 1);
    tick(); idle();
    wb.ex_we_i = 1'b1; wb.ex_waddr_i = 5'd4; wb.ex_wdata_i = 32'hAAAA;
    exp_a.push_back('{5'd4, 32'hAAAA, 1'b0});
    tick(); idle();
    wb.ex_we_i = 1'b1; wb.ex_waddr_i = 5'd1; wb.ex_wdata_i = 32'h11;
    lsu(5'd2, 32'h22);
    exp_a.push_back('{5'd1, 32'h11, 1'b0});
    exp_lsu.push_back('{5'd2, 32'h22, 1'b0});
    @(negedge clk);
    chk("nowaw_flag", wb.waw_conflict_o, 0);
    tick(); idle();

    // Scoreboard on x12
    wb.sb_set_i = 1'b1; wb.sb_addr_i = 5'd12;
    @(negedge clk); chk("sb_busy_before", wb.busy_o[12], 0);
    tick(); lsu(5'd12, 32'hC0);
    exp_lsu.push_back('{5'd12, 32'hC0, 1'b0});
    @(negedge clk); chk("sb_busy_set", wb.busy_o[12], 1);
    tick(); wb.sb_addr_i = 5'd0; lsu(5'd12, 32'hC1);
    exp_lsu.push_back('{5'd12, 32'hC1, 1'b0});
    @(negedge clk); chk("sb_set_wins", wb.busy_o[12], 1);
    tick(); idle();
    @(negedge clk); chk("sb_cleared_all", wb.busy_o, 0);
    tick();

    // Every producer targets x0
    wb.ex_we_i = 1'b1; wb.ex_waddr_i = 5'd0; wb.ex_wdata_i = 32'h5;
    lsu(5'd0, 32'h6);
    apu(5'd0, 32'h7);
    @(negedge clk);
    chk("x0_we_a", wb.we_a_o, 0);
    chk("x0_we_b", wb.we_b_o, 0);
    chk("x0_apu_ready", wb.apu_ready_o, 1);
    tick(); idle();
    apu(5'd6, 32'h66);
    exp_apu.push_back('{5'd6, 32'h66, 1'b0});
    @(negedge clk);
    chk("x0_pop_we_b", wb.we_b_o, 0);
    chk("x0_apu_ready2", wb.apu_ready_o, 1);
    tick(); idle();
    @(negedge clk); chk("x0_busy0", wb.busy_o[0], 0);
    tick(); tick();

    // Reset mid-operation with a full FIFO and a busy register
    lsu(5'd3, 32'h3A); apu(5'd14, 32'hE0);
    wb.sb_set_i = 1'b1; wb.sb_addr_i = 5'd20;
    exp_lsu.push_back('{5'd3, 32'h3A, 1'b0});
    tick(); lsu(5'd3, 32'h3B); apu(5'd15, 32'hF0); wb.sb_set_i = 1'b0;
    exp_lsu.push_back('{5'd3, 32'h3B, 1'b0});
    @(negedge clk);
    chk("mid_busy20", wb.busy_o[20], 1);
    chk("mid_ready", wb.apu_ready_o, 1);
    tick(); wb.apu_valid_i = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_we_b", wb.we_b_o, 0);
    chk("mid_rst_busy", wb.busy_o, 0);
    tick(); idle(); rst_n = 1'b1;
    @(negedge clk);
    chk("mid_post_ready", wb.apu_ready_o, 1);
    chk("mid_post_we_b", wb.we_b_o, 0);
    repeat (3) tick();

    chk("drain_a", exp_a.size(), 0);
    chk("drain_lsu", exp_lsu.size(), 0);
    chk("drain_apu", exp_apu.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
